// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the sync_ram bus-attached memory.
package sync_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Number of 8-bit byte lanes in a data word.
  function automatic int unsigned byte_lanes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sync_ram_if.sv
// Bus interface of sync_ram; parity_inject exists only with SYNC_RAM_PARITY_EN.
interface sync_ram_if
  import sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic [ADDR_WIDTH-1:0]                  addr;
  logic [DATA_WIDTH-1:0]                  data_in;
  logic [DATA_WIDTH-1:0]                  data_out;
  logic                                   data_oe;
  logic                                   select;
  logic                                   write;
  logic [byte_lanes(DATA_WIDTH)-1:0]      byte_en;
  logic                                   dtack;
  logic                                   berr;
`ifdef SYNC_RAM_PARITY_EN
  logic                                   parity_inject;
`endif

  modport master (
    output addr, data_in, select, write, byte_en,
`ifdef SYNC_RAM_PARITY_EN
    output parity_inject,
`endif
    input  data_out, data_oe, dtack, berr
  );

  modport slave (
    input  addr, data_in, select, write, byte_en,
`ifdef SYNC_RAM_PARITY_EN
    input  parity_inject,
`endif
    output data_out, data_oe, dtack, berr
  );

endinterface

// File: rtl/ram_array.sv
// Byte-lane storage for sync_ram: synchronous byte-enabled write, combinational
// read of the addressed word. With SYNC_RAM_PARITY_EN each lane also keeps an
// even-parity bit and flags a mismatch on the word being read.
module ram_array
  import sync_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RAM_SIZE   = 256,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] be,
  input  logic [IDX_W-1:0]                  idx,
  input  logic [DATA_WIDTH-1:0]             wdata,
`ifdef SYNC_RAM_PARITY_EN
  input  logic                              parity_inject,
  output logic                              par_err_c,
`endif
  output logic [DATA_WIDTH-1:0]             rdata_c
);

  localparam int unsigned LANES = byte_lanes(DATA_WIDTH);

`ifdef SYNC_RAM_PARITY_EN
  logic [LANES-1:0] lane_err_c;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] lane_mem [RAM_SIZE];
`ifdef SYNC_RAM_PARITY_EN
    logic       lane_par [RAM_SIZE];
`endif

    // Lane write: only when the word is committed and this byte is enabled.
    always_ff @(posedge clk) begin
      if (we && be[g]) begin
        lane_mem[idx] <= wdata[g*8 +: 8];
`ifdef SYNC_RAM_PARITY_EN
        lane_par[idx] <= (^wdata[g*8 +: 8]) ^ parity_inject;
`endif
      end
    end

    assign rdata_c[g*8 +: 8] = lane_mem[idx];
`ifdef SYNC_RAM_PARITY_EN
    assign lane_err_c[g] = ^{lane_mem[idx], lane_par[idx]};
`endif
  end

`ifdef SYNC_RAM_PARITY_EN
  assign par_err_c = |lane_err_c;
`endif

endmodule

// File: rtl/sync_ram.sv
// sync_ram: bus-attached word memory with programmable wait states, byte
// enables and address range error. Optional per-byte parity with error
// injection is enabled by defining SYNC_RAM_PARITY_EN.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RAM_SIZE    = 1 << ADDR_WIDTH,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       reset,
  sync_ram_if.slave  bus
);

  localparam int unsigned LANES = byte_lanes(DATA_WIDTH);
  localparam int unsigned IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

  state_t                  state_q, state_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic                    wr_q, wr_n;
  logic [LANES-1:0]        be_q, be_n;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_n;
  logic                    dtack_q, dtack_n;
  logic                    berr_q, berr_n;
  logic                    oe_q, oe_n;
  logic [DATA_WIDTH-1:0]   dout_q, dout_n;
  logic                    we_c;
  logic                    oob_c;
  logic                    par_err_c;
  logic [DATA_WIDTH-1:0]   rdata_c;
`ifdef SYNC_RAM_PARITY_EN
  logic                    inj_q, inj_n;
`endif

  assign oob_c = (32'(addr_q) >= 32'(RAM_SIZE));

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_SIZE   (RAM_SIZE),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk           (clk),
    .we            (we_c & ~reset),
    .be            (be_q),
    .idx           (addr_q[IDX_W-1:0]),
    .wdata         (wdat_q),
`ifdef SYNC_RAM_PARITY_EN
    .parity_inject (inj_q),
    .par_err_c     (par_err_c),
`endif
    .rdata_c       (rdata_c)
  );

`ifndef SYNC_RAM_PARITY_EN
  assign par_err_c = 1'b0;
`endif

  // State, request latch and registered bus outputs; reset leaves memory intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdat_q  <= '0;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
`ifdef SYNC_RAM_PARITY_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      wr_q    <= wr_n;
      be_q    <= be_n;
      wdat_q  <= wdat_n;
      dtack_q <= dtack_n;
      berr_q  <= berr_n;
      oe_q    <= oe_n;
      dout_q  <= dout_n;
`ifdef SYNC_RAM_PARITY_EN
      inj_q   <= inj_n;
`endif
    end
  end

  // Bus cycle sequencing: latch, count wait states, access, hold until select drops.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    wr_n    = wr_q;
    be_n    = be_q;
    wdat_n  = wdat_q;
    dtack_n = dtack_q;
    berr_n  = berr_q;
    oe_n    = oe_q;
    dout_n  = dout_q;
    we_c    = 1'b0;
`ifdef SYNC_RAM_PARITY_EN
    inj_n   = inj_q;
`endif

    unique case (state_q)
      IDLE: begin
        dtack_n = 1'b0;
        berr_n  = 1'b0;
        oe_n    = 1'b0;
        if (bus.select) begin
          addr_n  = bus.addr;
          wr_n    = bus.write;
          be_n    = bus.byte_en;
          wdat_n  = bus.data_in;
          cnt_n   = CNT_W'(WAIT_STATES);
`ifdef SYNC_RAM_PARITY_EN
          inj_n   = bus.parity_inject;
`endif
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (!bus.select) begin
          state_n = IDLE;
        end else if (cnt_q == '0) begin
          if (oob_c) begin
            berr_n  = 1'b1;
            state_n = ERR;
          end else if (wr_q) begin
            we_c    = 1'b1;
            dtack_n = 1'b1;
            state_n = ACK;
          end else begin
            dout_n = rdata_c;
            if (par_err_c) begin
              berr_n  = 1'b1;
              state_n = ERR;
            end else begin
              dtack_n = 1'b1;
              oe_n    = 1'b1;
              state_n = ACK;
            end
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      ACK, ERR: begin
        if (!bus.select) begin
          dtack_n = 1'b0;
          berr_n  = 1'b0;
          oe_n    = 1'b0;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.data_out = dout_q;
  assign bus.data_oe  = oe_q;
  assign bus.dtack    = dtack_q;
  assign bus.berr     = berr_q;

endmodule

// File: tb/tb_sync_ram.sv
// Directed bench for sync_ram: u1 has WAIT_STATES=1, RAM_SIZE=256;
// u3 has WAIT_STATES=3 and the full address range.
module tb_sync_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;
  logic        wr = 1'b0;
  logic [1:0]  be = '0;
  logic        inj = 1'b0;
  logic        sel1 = 1'b0;
  logic        sel3 = 1'b0;

  int errors = 0;
  int checks = 0;

  sync_ram_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b1 ();
  sync_ram_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b3 ();

  assign b1.addr = addr;   assign b3.addr = addr;
  assign b1.data_in = din; assign b3.data_in = din;
  assign b1.write = wr;    assign b3.write = wr;
  assign b1.byte_en = be;  assign b3.byte_en = be;
  assign b1.select = sel1; assign b3.select = sel3;
`ifdef SYNC_RAM_PARITY_EN
  assign b1.parity_inject = inj;
  assign b3.parity_inject = inj;
`endif

  sync_ram #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_SIZE(256), .WAIT_STATES(1))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  sync_ram #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(3))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic get(input int which, output logic [15:0] q, output logic dt,
                     output logic bo, output logic oe);
    if (which == 1) begin
      q = b1.data_out; dt = b1.dtack; bo = b1.berr; oe = b1.data_oe;
    end else begin
      q = b3.data_out; dt = b3.dtack; bo = b3.berr; oe = b3.data_oe;
    end
  endtask

  // One complete bus cycle; inputs are scrambled after E0 to show they are latched.
  task automatic run_cycle(input int which, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic [1:0] b, input logic pi,
                           output int lat, output logic [15:0] q, output logic dt,
                           output logic bo, output logic oe);
    logic [15:0] q2;
    logic dt2, bo2, oe2;
    addr = a; din = d; wr = w; be = b; inj = pi;
    if (which == 1) sel1 = 1'b1; else sel3 = 1'b1;
    lat = 0; dt = 1'b0; bo = 1'b0; oe = 1'b0; q = '0;
    while (!(dt || bo) && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        addr = ~a; din = ~d; be = ~b; wr = ~w; inj = ~pi;
      end
      get(which, q, dt, bo, oe);
    end
    sel1 = 1'b0; sel3 = 1'b0;
    tick();
    get(which, q2, dt2, bo2, oe2);
    chk("release_outputs", {29'd0, dt2, bo2, oe2}, 32'd0);
  endtask

  int          lat;
  logic [15:0] q;
  logic        dt, bo, oe;
  logic        seen;

  initial begin
    // Reset state
    tick(); tick();
    chk("reset_dtack", {31'd0, b1.dtack}, 32'd0);
    chk("reset_berr", {31'd0, b1.berr}, 32'd0);
    chk("reset_oe", {31'd0, b1.data_oe}, 32'd0);
    chk("reset_dout", {16'd0, b1.data_out}, 32'd0);
    reset = 1'b0;
    tick();

    // Full write then read back, dtack after E2
    run_cycle(1, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("wr_latency", lat, 32'd3);
    chk("wr_dtack", {29'd0, dt, bo, oe}, 32'b100);
    run_cycle(1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, lat, q, dt, bo, oe);
    chk("rd_latency", lat, 32'd3);
    chk("rd_flags", {29'd0, dt, bo, oe}, 32'b101);
    chk("rd_data", {16'd0, q}, 32'h0000BEEF);

    // Low byte only
    run_cycle(1, 1'b1, 16'h0010, 16'h12FF, 2'b01, 1'b0, lat, q, dt, bo, oe);
    run_cycle(1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("be01_data", {16'd0, q}, 32'h0000BEFF);

    // No byte enabled: still acknowledged, nothing changes
    run_cycle(1, 1'b1, 16'h0010, 16'h0000, 2'b00, 1'b0, lat, q, dt, bo, oe);
    chk("be00_dtack", {29'd0, dt, bo, oe}, 32'b100);
    run_cycle(1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("be00_data", {16'd0, q}, 32'h0000BEFF);

    // High byte only at another location
    run_cycle(1, 1'b1, 16'h0040, 16'hBEEF, 2'b11, 1'b0, lat, q, dt, bo, oe);
    run_cycle(1, 1'b1, 16'h0040, 16'h34AA, 2'b10, 1'b0, lat, q, dt, bo, oe);
    run_cycle(1, 1'b0, 16'h0040, 16'h0000, 2'b01, 1'b0, lat, q, dt, bo, oe);
    chk("be10_data", {16'd0, q}, 32'h000034EF);

    // Out-of-range read and write; the write must not alias onto word 0
    run_cycle(1, 1'b1, 16'h0000, 16'h5A5A, 2'b11, 1'b0, lat, q, dt, bo, oe);
    run_cycle(1, 1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("oob_rd_flags", {29'd0, dt, bo, oe}, 32'b010);
    run_cycle(1, 1'b1, 16'h0100, 16'hFFFF, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("oob_wr_flags", {29'd0, dt, bo, oe}, 32'b010);
    run_cycle(1, 1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("oob_no_alias", {16'd0, q}, 32'h00005A5A);

    // berr holds while select high, clears on the edge after select drops
    addr = 16'h0100; wr = 1'b0; sel1 = 1'b1;
    repeat (4) tick();
    chk("berr_hold", {30'd0, b1.berr, b1.dtack}, 32'b10);
    sel1 = 1'b0;
    chk("berr_before_edge", {31'd0, b1.berr}, 32'd1);
    tick();
    chk("berr_cleared", {31'd0, b1.berr}, 32'd0);

    // dtack and data_oe hold while select stays high
    addr = 16'h0010; wr = 1'b0; be = 2'b00; sel1 = 1'b1;
    repeat (5) tick();
    chk("ack_hold", {30'd0, b1.dtack, b1.data_oe}, 32'b11);
    sel1 = 1'b0;
    tick();

    // WAIT_STATES=3: latency and abort in WAIT
    run_cycle(3, 1'b1, 16'h0010, 16'hBEFF, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("ws3_latency", lat, 32'd5);
    addr = 16'h0010; din = 16'h0000; wr = 1'b1; be = 2'b11; sel3 = 1'b1;
    tick(); tick();
    sel3 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | b3.dtack | b3.berr;
    end
    chk("abort_no_ack", {31'd0, seen}, 32'd0);
    run_cycle(3, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("abort_data", {16'd0, q}, 32'h0000BEFF);

    // Reset on the commit edge of a write
    run_cycle(1, 1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, lat, q, dt, bo, oe);
    run_cycle(1, 1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("pre_reset_data", {16'd0, q}, 32'h00001234);
    addr = 16'h0020; din = 16'hAAAA; wr = 1'b1; be = 2'b11; sel1 = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("commit_reset_flags", {29'd0, b1.dtack, b1.berr, b1.data_oe}, 32'd0);
    chk("commit_reset_dout", {16'd0, b1.data_out}, 32'd0);
    reset = 1'b0; sel1 = 1'b0;
    tick();
    run_cycle(1, 1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("commit_reset_data", {16'd0, q}, 32'h00001234);

`ifdef SYNC_RAM_PARITY_EN
    // Injected parity error, then clean rewrite
    run_cycle(1, 1'b1, 16'h0030, 16'h5555, 2'b11, 1'b1, lat, q, dt, bo, oe);
    run_cycle(1, 1'b0, 16'h0030, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("par_err_flags", {29'd0, dt, bo, oe}, 32'b010);
    chk("par_err_data", {16'd0, q}, 32'h00005555);
    run_cycle(1, 1'b1, 16'h0030, 16'h5555, 2'b11, 1'b0, lat, q, dt, bo, oe);
    run_cycle(1, 1'b0, 16'h0030, 16'h0000, 2'b11, 1'b0, lat, q, dt, bo, oe);
    chk("par_ok_flags", {29'd0, dt, bo, oe}, 32'b101);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
